// File: rtl/spi_gpio_regs.sv
// spi_gpio_regs - SPI slave register bank driving a bank of GPIO pins.
//
// An external SPI master sends one frame per SSEL-low window: a command
// byte (bit 7 = write, bits 6:0 = address) followed by NUM_PINS data bits.
// Reads shift the addressed register out on MISO during the data phase.
//
// Registers: 0x00 OUT (r/w), 0x01 DIR (r/w, 1 = drive), 0x02 IN (ro),
//            0x03 IRQ_STAT (w1c, only when GPIO_IRQ_EN is defined).
//
// Optional feature macro: GPIO_IRQ_EN (per-pin change interrupt).
//
// Ports:
//   clk_i        system clock (>= 4x SCK)
//   rst_ni       asynchronous active-low reset
//   sck_i        SPI clock (async to clk_i)
//   ssel_i       SPI select, active low
//   mosi_i       SPI data in
//   miso_o       SPI data out
//   miso_oe_o    MISO output enable, high while synchronised SSEL is low
//   gpio_in_i    pad input values
//   gpio_out_o   OUT register
//   gpio_oe_o    DIR register
//   irq_o        change interrupt (0 when GPIO_IRQ_EN is undefined)
//   dbg_state_o  frame FSM state (0 IDLE, 1 CMD, 2 DATA, 3 DONE)
module spi_gpio_regs #(
    parameter int NUM_PINS  = 16,
    parameter bit CPOL      = 1'b1,
    parameter bit CPHA      = 1'b1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sck_i,
    input  logic                ssel_i,
    input  logic                mosi_i,
    output logic                miso_o,
    output logic                miso_oe_o,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    output logic [NUM_PINS-1:0] gpio_out_o,
    output logic [NUM_PINS-1:0] gpio_oe_o,
    output logic                irq_o,
    output logic [1:0]          dbg_state_o
);

    localparam int FRAME_W = 8 + NUM_PINS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // [0],[1] synchroniser stages, [2] previous synchronised sample for edges.
    logic [2:0]          sck_q;
    logic [2:0]          ssel_q;
    logic [1:0]          mosi_q;
    logic [NUM_PINS-1:0] gpio_meta_q;
    logic [NUM_PINS-1:0] gpio_sync_q;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          cmd_q;
    logic [NUM_PINS-1:0] data_q;
    logic [NUM_PINS-1:0] rd_q;
    logic                miso_q;
    logic                miso_oe_q;
    logic [NUM_PINS-1:0] out_q;
    logic [NUM_PINS-1:0] dir_q;
    logic                wr_pend_q;

    logic                sck_rise, sck_fall, sample_edge, shift_edge;
    logic                ssel_fall, ssel_rise, mosi_s;
    logic [7:0]          cmd_d;
    logic [NUM_PINS-1:0] data_d;
    logic [NUM_PINS-1:0] rd_shift_d;
    logic                rd_bit;
    logic [NUM_PINS-1:0] rd_val;

    // Synchronisers reset to 0 (SSEL included): if SSEL is already low when
    // reset is released no falling edge is seen, so a frame in progress is
    // ignored until SSEL goes high and falls again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q       <= '0;
            ssel_q      <= '0;
            mosi_q      <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
        end else begin
            sck_q       <= {sck_q[1:0], sck_i};
            ssel_q      <= {ssel_q[1:0], ssel_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            gpio_meta_q <= gpio_in_i;
            gpio_sync_q <= gpio_meta_q;
        end
    end

    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
    assign ssel_fall   = ~ssel_q[1] & ssel_q[2];
    assign ssel_rise   = ssel_q[1] & ~ssel_q[2];
    assign mosi_s      = mosi_q[1];

    assign cmd_d      = LSB_FIRST ? {mosi_s, cmd_q[7:1]} : {cmd_q[6:0], mosi_s};
    assign data_d     = LSB_FIRST ? ((data_q >> 1) | (NUM_PINS'(mosi_s) << (NUM_PINS - 1)))
                                  : ((data_q << 1) | NUM_PINS'(mosi_s));
    assign rd_shift_d = LSB_FIRST ? (rd_q >> 1) : (rd_q << 1);
    assign rd_bit     = LSB_FIRST ? rd_q[0] : rd_q[NUM_PINS-1];

`ifdef GPIO_IRQ_EN
    logic [NUM_PINS-1:0] irq_stat_q;
    logic [NUM_PINS-1:0] gpio_prev_q;
    logic [NUM_PINS-1:0] irq_set;
    logic [NUM_PINS-1:0] irq_clr;
    logic                irq_q;
`endif

    // Readback value, decoded from the completed command byte (cmd_d) in
    // the cycle of the 8th sample. Write commands shift out zeros.
    always_comb begin
        rd_val = '0;
        if (!cmd_d[7]) begin
            case (cmd_d[6:0])
                7'h00:   rd_val = out_q;
                7'h01:   rd_val = dir_q;
                7'h02:   rd_val = gpio_sync_q;
`ifdef GPIO_IRQ_EN
                7'h03:   rd_val = irq_stat_q;
`endif
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            rd_q      <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            out_q     <= '0;
            dir_q     <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            wr_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ssel_fall) begin
                        // A sample edge in the same cycle is the frame's first bit.
                        state_q   <= S_CMD;
                        miso_oe_q <= 1'b1;
                        miso_q    <= 1'b0;
                        cnt_q     <= sample_edge ? CNT_W'(1) : '0;
                        if (sample_edge) cmd_q <= cmd_d;
                    end else if (ssel_rise) begin
                        miso_oe_q <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (ssel_rise) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else if (sample_edge) begin
                        cmd_q <= cmd_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CMD_LAST) begin
                            rd_q    <= rd_val;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (ssel_rise) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else if (sample_edge) begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == FRAME_LAST) begin
                            state_q   <= S_DONE;
                            wr_pend_q <= 1'b1;
                            miso_q    <= 1'b0;
                        end
                    end else if (shift_edge) begin
                        miso_q <= rd_bit;
                        rd_q   <= rd_shift_d;
                    end
                end
                S_DONE: begin
                    // Counter stays at FRAME_W; SCK is ignored until SSEL rises.
                    miso_q <= 1'b0;
                    if (ssel_rise) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        miso_oe_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Register write lands one cycle after the final sample was taken.
            if (wr_pend_q && cmd_q[7]) begin
                if (cmd_q[6:0] == 7'h00) out_q <= data_q;
                if (cmd_q[6:0] == 7'h01) dir_q <= data_q;
            end
        end
    end

`ifdef GPIO_IRQ_EN
    // Only input pins (DIR=0) raise change events; set beats a same-cycle clear.
    assign irq_set = (gpio_sync_q ^ gpio_prev_q) & ~dir_q;
    assign irq_clr = (wr_pend_q && cmd_q[7] && (cmd_q[6:0] == 7'h03)) ? data_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_stat_q  <= '0;
            gpio_prev_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            irq_stat_q  <= (irq_stat_q & ~irq_clr) | irq_set;
            gpio_prev_q <= gpio_sync_q;
            irq_q       <= |irq_stat_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign miso_o      = miso_q;
    assign miso_oe_o   = miso_oe_q;
    assign gpio_out_o  = out_q;
    assign gpio_oe_o   = dir_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_gpio_regs.sv
// Bench for spi_gpio_regs: instance 0 is mode 3 MSB first, instance 1 is
// mode 0 LSB first, both with 16 pins. A register-level model (OUT/DIR
// arrays) predicts the pins; reads are checked through an expected queue.
`timescale 1ns/1ps
module tb_spi_gpio_regs;
  localparam int NP = 16;
  localparam int FRAME_W = 8 + NP;
  localparam int HALF = 4;  // SCK half period in CLK cycles
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sck [2];
  logic          ssel [2];
  logic          mosi [2];
  logic          miso [2];
  logic          miso_oe [2];
  logic [NP-1:0] gpio_in [2];
  logic [NP-1:0] gpio_out [2];
  logic [NP-1:0] gpio_oe [2];
  logic          irq [2];
  logic [1:0]    dbg [2];

  spi_gpio_regs #(.NUM_PINS(NP), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck[0]), .ssel_i(ssel[0]), .mosi_i(mosi[0]),
    .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .gpio_in_i(gpio_in[0]),
    .gpio_out_o(gpio_out[0]), .gpio_oe_o(gpio_oe[0]), .irq_o(irq[0]), .dbg_state_o(dbg[0])
  );

  spi_gpio_regs #(.NUM_PINS(NP), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck[1]), .ssel_i(ssel[1]), .mosi_i(mosi[1]),
    .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .gpio_in_i(gpio_in[1]),
    .gpio_out_o(gpio_out[1]), .gpio_oe_o(gpio_oe[1]), .irq_o(irq[1]), .dbg_state_o(dbg[1])
  );

  // ---------------- scoreboard / model ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [NP-1:0] m_out [2];
  logic [NP-1:0] m_dir [2];
  bit settling [2];
  logic [NP-1:0] exp_q [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [NP-1:0] model_read(input int w, input logic [6:0] addr);
    case (addr)
      7'h00:   return m_out[w];
      7'h01:   return m_dir[w];
      7'h02:   return gpio_in[w];
      default: return '0;
    endcase
  endfunction

  function automatic void model_write(input int w, input logic [6:0] addr, input logic [NP-1:0] d);
    if (addr == 7'h00) m_out[w] = d;
    else if (addr == 7'h01) m_dir[w] = d;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < 2; w++) begin
      m_out[w] = '0;
      m_dir[w] = '0;
    end
  endfunction

  // Every cycle outside the post-write latency window the pins must match the model.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (!settling[w]) begin
        chk(w == 0 ? "cyc_out0" : "cyc_out1", 32'(gpio_out[w]), 32'(m_out[w]));
        chk(w == 0 ? "cyc_oe0" : "cyc_oe1", 32'(gpio_oe[w]), 32'(m_dir[w]));
        if (!IRQ_EN) chk(w == 0 ? "cyc_irq0" : "cyc_irq1", 32'(irq[w]), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic bit_of(input logic [7:0] cmd, input logic [NP-1:0] data,
                                  input int i, input bit lsb);
    if (i < 8) return lsb ? cmd[i] : cmd[7-i];
    return lsb ? data[i-8] : data[NP-1-(i-8)];
  endfunction

  // One SSEL-low window of nbits bits (nbits < FRAME_W aborts the frame).
  task automatic spi_xfer(input int w, input logic [7:0] cmd, input logic [NP-1:0] data,
                          input int nbits, output logic [NP-1:0] rd);
    bit lsb;
    bit cpol;
    bit cpha;
    bit full;
    lsb  = (w == 1);
    cpol = (w == 0);
    cpha = (w == 0);
    full = (nbits == FRAME_W);
    rd = '0;
    if (!cpha) mosi[w] = bit_of(cmd, data, 0, lsb);
    ssel[w] = 1'b0;
    wait_clks(HALF);
    chk("miso_oe_on", 32'(miso_oe[w]), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        if (i >= 8) rd[lsb ? (i-8) : (NP-1-(i-8))] = miso[w];
        sck[w] = ~cpol;  // leading edge samples
        if (full && i == FRAME_W-1) begin
          settling[w] = 1'b1;
          if (cmd[7]) model_write(w, cmd[6:0], data);
        end
        wait_clks(HALF);
        if (full && i == FRAME_W-1) begin
          chk("lat_out", 32'(gpio_out[w]), 32'(m_out[w]));
          chk("lat_oe", 32'(gpio_oe[w]), 32'(m_dir[w]));
          settling[w] = 1'b0;
        end
        sck[w] = cpol;
        if (i + 1 < nbits) mosi[w] = bit_of(cmd, data, i + 1, lsb);
        wait_clks(HALF);
      end else begin
        sck[w] = ~cpol;  // leading edge shifts
        mosi[w] = bit_of(cmd, data, i, lsb);
        wait_clks(HALF);
        if (i >= 8) rd[lsb ? (i-8) : (NP-1-(i-8))] = miso[w];
        sck[w] = cpol;   // trailing edge samples
        if (full && i == FRAME_W-1) begin
          settling[w] = 1'b1;
          if (cmd[7]) model_write(w, cmd[6:0], data);
        end
        wait_clks(HALF);
        if (full && i == FRAME_W-1) begin
          chk("lat_out", 32'(gpio_out[w]), 32'(m_out[w]));
          chk("lat_oe", 32'(gpio_oe[w]), 32'(m_dir[w]));
          settling[w] = 1'b0;
        end
      end
    end
    if (full) chk("miso_done", 32'(miso[w]), 32'd0);
    ssel[w] = 1'b1;
    wait_clks(HALF);
    chk("miso_oe_off", 32'(miso_oe[w]), 32'd0);
    chk("miso_idle", 32'(miso[w]), 32'd0);
  endtask

  task automatic read_reg(input int w, input logic [6:0] addr, input string name);
    logic [NP-1:0] rd;
    exp_q.push_back(model_read(w, addr));
    spi_xfer(w, {1'b0, addr}, '0, FRAME_W, rd);
    chk(name, 32'(rd), 32'(exp_q.pop_front()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NP-1:0] rd;
    model_reset();
    for (int w = 0; w < 2; w++) begin
      settling[w] = 1'b0;
      ssel[w] = 1'b1;
      sck[w] = (w == 0);
      mosi[w] = 1'b0;
      gpio_in[w] = '0;
    end
    wait_clks(3);
    for (int w = 0; w < 2; w++) begin
      chk("rst_out", 32'(gpio_out[w]), 32'd0);
      chk("rst_oe", 32'(gpio_oe[w]), 32'd0);
      chk("rst_miso", 32'(miso[w]), 32'd0);
      chk("rst_miso_oe", 32'(miso_oe[w]), 32'd0);
      chk("rst_irq", 32'(irq[w]), 32'd0);
      chk("rst_state", 32'(dbg[w]), 32'd0);
    end
    rst_n = 1'b1;
    wait_clks(6);

    // Mode 3 write OUT, then read IN.
    spi_xfer(0, 8'h80, 16'h00CC, FRAME_W, rd);
    chk("tp1_out", 32'(gpio_out[0]), 32'h00CC);
    chk("tp1_oe", 32'(gpio_oe[0]), 32'h0000);
    gpio_in[0] = 16'hA55A;
    wait_clks(4);
    spi_xfer(0, 8'h02, '0, FRAME_W, rd);
    chk("tp2_rd_in", 32'(rd), 32'hA55A);

    // Aborted write leaves DIR alone; full write lands.
    spi_xfer(0, 8'h81, 16'hFFFF, 16, rd);
    chk("tp3_abort_oe", 32'(gpio_oe[0]), 32'h0000);
    spi_xfer(0, 8'h81, 16'hFFFF, FRAME_W, rd);
    chk("tp3_oe", 32'(gpio_oe[0]), 32'hFFFF);

    // Mode 0 LSB-first instance.
    spi_xfer(1, 8'h80, 16'h1234, FRAME_W, rd);
    chk("tp4_out", 32'(gpio_out[1]), 32'h1234);
    spi_xfer(1, 8'h00, '0, FRAME_W, rd);
    chk("tp4_rd", 32'(rd), 32'h1234);

    // RO / unmapped accesses.
    spi_xfer(0, 8'h82, 16'hFFFF, FRAME_W, rd);
    chk("tp5_out", 32'(gpio_out[0]), 32'h00CC);
    chk("tp5_oe", 32'(gpio_oe[0]), 32'hFFFF);
    spi_xfer(0, 8'h7F, '0, FRAME_W, rd);
    chk("tp5_rd_unmapped", 32'(rd), 32'h0000);
    read_reg(0, 7'h03, IRQ_EN ? "rd_irqstat" : "rd_03_unmapped");

    // Reset in the middle of a frame; remaining bits must be ignored.
    ssel[0] = 1'b0;
    mosi[0] = 1'b1;
    wait_clks(HALF);
    for (int i = 0; i < 5; i++) begin
      sck[0] = 1'b0; wait_clks(HALF);
      sck[0] = 1'b1; wait_clks(HALF);
    end
    rst_n = 1'b0;
    model_reset();
    wait_clks(3);
    chk("mrst_out", 32'(gpio_out[0]), 32'd0);
    chk("mrst_oe", 32'(gpio_oe[0]), 32'd0);
    chk("mrst_miso_oe", 32'(miso_oe[0]), 32'd0);
    chk("mrst_out1", 32'(gpio_out[1]), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      sck[0] = 1'b0; wait_clks(HALF);
      sck[0] = 1'b1; wait_clks(HALF);
    end
    chk("mrst_partial_oe", 32'(miso_oe[0]), 32'd0);
    ssel[0] = 1'b1;
    mosi[0] = 1'b0;
    wait_clks(2 * HALF);
    chk("mrst_partial_out", 32'(gpio_out[0]), 32'd0);
    spi_xfer(0, 8'h80, 16'h5A5A, FRAME_W, rd);
    chk("mrst_next_out", 32'(gpio_out[0]), 32'h5A5A);

`ifdef GPIO_IRQ_EN
    gpio_in[0] = '0;
    spi_xfer(0, 8'h81, 16'h0000, FRAME_W, rd);
    wait_clks(6);
    spi_xfer(0, 8'h83, 16'hFFFF, FRAME_W, rd);
    wait_clks(4);
    spi_xfer(0, 8'h03, '0, FRAME_W, rd);
    chk("irq_clear0", 32'(rd), 32'h0000);
    chk("irq_low0", 32'(irq[0]), 32'd0);
    gpio_in[0][3] = 1'b1;
    wait_clks(8);
    spi_xfer(0, 8'h03, '0, FRAME_W, rd);
    chk("irq_stat", 32'(rd), 32'h0008);
    chk("irq_high", 32'(irq[0]), 32'd1);
    spi_xfer(0, 8'h83, 16'h0008, FRAME_W, rd);
    wait_clks(4);
    spi_xfer(0, 8'h03, '0, FRAME_W, rd);
    chk("irq_clear1", 32'(rd), 32'h0000);
    chk("irq_low1", 32'(irq[0]), 32'd0);
`endif

    // Randomised traffic on both instances.
    for (int n = 0; n < 48; n++) begin
      int w;
      int nb;
      logic [6:0] addr;
      logic [NP-1:0] d;
      bit wr;
      w = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: addr = 7'h00;
        1: addr = 7'h01;
        2: addr = 7'h02;
        3: addr = IRQ_EN ? 7'h02 : 7'h03;
        4: addr = 7'h00;
        default: addr = 7'($urandom_range(4, 127));
      endcase
      wr = ($urandom_range(0, 1) == 1);
      d = NP'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FRAME_W - 1) : FRAME_W;
      gpio_in[w] = NP'($urandom);
      wait_clks(4);
      if (wr || nb != FRAME_W) begin
        spi_xfer(w, {wr, addr}, d, nb, rd);
      end else begin
        read_reg(w, addr, "rnd_read");
      end
    end
    wait_clks(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule
